// File: rtl/reg_sched_pkg.sv
// Shared definitions for the register-bank scheduler: op codes, register
// FunSel codes, FSM state encoding and op decode helpers.
package reg_sched_pkg;

    localparam logic [2:0] OP_DEC = 3'd0;
    localparam logic [2:0] OP_INC = 3'd1;
    localparam logic [2:0] OP_CLR = 3'd2;
    localparam logic [2:0] OP_LDZ = 3'd3;
    localparam logic [2:0] OP_LDS = 3'd4;
    localparam logic [2:0] OP_LDW = 3'd5;

    localparam logic [2:0] FS_DEC  = 3'b000;
    localparam logic [2:0] FS_INC  = 3'b001;
    localparam logic [2:0] FS_LOAD = 3'b010;
    localparam logic [2:0] FS_CLR  = 3'b011;
    localparam logic [2:0] FS_ZEXT = 3'b100;
    localparam logic [2:0] FS_LO   = 3'b101;
    localparam logic [2:0] FS_HI   = 3'b110;
    localparam logic [2:0] FS_SEXT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXEC    = 2'd1,
        ST_EXEC_HI = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Codes 6 and 7 are reserved and must never write a register.
    function automatic logic op_legal(input logic [2:0] op);
        return (op <= OP_LDW);
    endfunction

    // Ops that place byte data on I[7:0]; the rest drive I to zero.
    function automatic logic op_is_load(input logic [2:0] op);
        return (op == OP_LDZ) || (op == OP_LDS) || (op == OP_LDW);
    endfunction

    // FunSel for the first (or only) write of an op; LDW starts with the low byte.
    function automatic logic [2:0] op_funsel(input logic [2:0] op);
        logic [2:0] fs;
        case (op)
            OP_DEC:  fs = FS_DEC;
            OP_INC:  fs = FS_INC;
            OP_CLR:  fs = FS_CLR;
            OP_LDZ:  fs = FS_ZEXT;
            OP_LDS:  fs = FS_SEXT;
            OP_LDW:  fs = FS_LO;
            default: fs = FS_DEC;
        endcase
        return fs;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. Grant is combinational from the
// requests and a 1-bit priority pointer; the pointer moves to the
// requester that did not own the finished operation when i_advance pulses.
module rr_arbiter2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    input  logic       i_owner,
    output logic [1:0] o_gnt
);

    logic r_ptr;

    // Priority pointer: 0 favours requester 0 (A), 1 favours requester 1 (B).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= 1'b0;
        end else if (i_advance) begin
            r_ptr <= ~i_owner;
        end
    end

    // A lone requester always wins; on a tie the pointer holder wins.
    always_comb begin
        o_gnt[0] = i_req[0] & (~i_req[1] | ~r_ptr);
        o_gnt[1] = i_req[1] & (~i_req[0] |  r_ptr);
    end

endmodule

// File: rtl/reg_bank_scheduler.sv
// Sequencer and 2-way arbiter driving a bank of four 16-bit registers over
// a shared FunSel/I bus with a one-hot enable. Word loads are split into a
// low-byte and a high-byte write.
module reg_bank_scheduler
    import reg_sched_pkg::*;
#(
    parameter int NREG = 4
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            ReqA,
    input  logic            ReqB,
    input  logic [2:0]      OpA,
    input  logic [2:0]      OpB,
    input  logic [1:0]      SelA,
    input  logic [1:0]      SelB,
    input  logic [15:0]     DataA,
    input  logic [15:0]     DataB,
    output logic            GntA,
    output logic            GntB,
    output logic            DoneA,
    output logic            DoneB,
    output logic            Err,
    output logic [2:0]      FunSel,
    output logic [15:0]     I,
    output logic [NREG-1:0] E,
    output logic            Busy
);

    state_t          r_state;
    logic            r_owner;
    logic            r_gnt_a;
    logic            r_gnt_b;
    logic            r_done_a;
    logic            r_done_b;
    logic            r_err;
    logic [2:0]      r_funsel;
    logic [15:0]     r_i;
    logic [NREG-1:0] r_e;
    logic [2:0]      r_op;
    logic [7:0]      r_data_hi;

    logic [1:0]      w_gnt;
    logic            w_start;
    logic            w_advance;
    logic [2:0]      w_op;
    logic [1:0]      w_sel;
    logic [15:0]     w_data;
    logic [NREG-1:0] w_onehot;

    assign w_start   = (r_state == ST_IDLE) && (w_gnt != 2'b00);
    assign w_advance = (r_state == ST_DONE);

    rr_arbiter2 u_arb (
        .i_clk     (Clock),
        .i_rst     (Reset),
        .i_req     ({ReqB, ReqA}),
        .i_advance (w_advance),
        .i_owner   (r_owner),
        .o_gnt     (w_gnt)
    );

    // Select the winning requester's operation for latching in IDLE.
    always_comb begin
        w_op     = w_gnt[1] ? OpB   : OpA;
        w_sel    = w_gnt[1] ? SelB  : SelA;
        w_data   = w_gnt[1] ? DataB : DataA;
        w_onehot = {{(NREG-1){1'b0}}, 1'b1} << w_sel;
    end

    // Request latch: only the op code and the high data byte are needed after EXEC starts.
    always_ff @(posedge Clock) begin
        if (w_start) begin
            r_op      <= w_op;
            r_data_hi <= w_data[15:8];
        end
    end

    // Control FSM with registered bus, enable, grant and completion outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state  <= ST_IDLE;
            r_owner  <= 1'b0;
            r_gnt_a  <= 1'b0;
            r_gnt_b  <= 1'b0;
            r_done_a <= 1'b0;
            r_done_b <= 1'b0;
            r_err    <= 1'b0;
            r_e      <= '0;
            r_funsel <= FS_DEC;
            r_i      <= 16'h0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_EXEC;
                        r_owner <= w_gnt[1];
                        r_gnt_a <= w_gnt[0];
                        r_gnt_b <= w_gnt[1];
                        if (op_legal(w_op)) begin
                            r_e      <= w_onehot;
                            r_funsel <= op_funsel(w_op);
                            r_i      <= op_is_load(w_op) ? {8'h00, w_data[7:0]} : 16'h0000;
                        end
                    end
                end
                ST_EXEC: begin
                    if (r_op == OP_LDW) begin
                        // Keep the enable; switch the bus to the high byte.
                        r_state  <= ST_EXEC_HI;
                        r_funsel <= FS_HI;
                        r_i      <= {8'h00, r_data_hi};
                    end else begin
                        r_state  <= ST_DONE;
                        r_e      <= '0;
                        r_funsel <= FS_DEC;
                        r_i      <= 16'h0000;
                        r_done_a <= ~r_owner;
                        r_done_b <= r_owner;
                        r_err    <= ~op_legal(r_op);
                    end
                end
                ST_EXEC_HI: begin
                    r_state  <= ST_DONE;
                    r_e      <= '0;
                    r_funsel <= FS_DEC;
                    r_i      <= 16'h0000;
                    r_done_a <= ~r_owner;
                    r_done_b <= r_owner;
                    r_err    <= 1'b0;
                end
                ST_DONE: begin
                    r_state  <= ST_IDLE;
                    r_gnt_a  <= 1'b0;
                    r_gnt_b  <= 1'b0;
                    r_done_a <= 1'b0;
                    r_done_b <= 1'b0;
                    r_err    <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign GntA   = r_gnt_a;
    assign GntB   = r_gnt_b;
    assign DoneA  = r_done_a;
    assign DoneB  = r_done_b;
    assign Err    = r_err;
    assign FunSel = r_funsel;
    assign I      = r_i;
    assign E      = r_e;
    assign Busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_reg_bank_scheduler.sv
// Directed bench for reg_bank_scheduler with a behavioural model of the
// four-register bank driven by the DUT's E/FunSel/I outputs.
module tb_reg_bank_scheduler;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        ReqA, ReqB;
    logic [2:0]  OpA, OpB;
    logic [1:0]  SelA, SelB;
    logic [15:0] DataA, DataB;
    logic        GntA, GntB, DoneA, DoneB, Err, Busy;
    logic [2:0]  FunSel;
    logic [15:0] I;
    logic [3:0]  E;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [15:0] m_reg [4];
    logic        pre_en = 1'b0;
    logic [1:0]  pre_idx = 2'd0;
    logic [15:0] pre_val = 16'h0000;

    reg_bank_scheduler #(.NREG(4)) dut (
        .Clock (Clock), .Reset (Reset),
        .ReqA (ReqA), .ReqB (ReqB), .OpA (OpA), .OpB (OpB),
        .SelA (SelA), .SelB (SelB), .DataA (DataA), .DataB (DataB),
        .GntA (GntA), .GntB (GntB), .DoneA (DoneA), .DoneB (DoneB),
        .Err (Err), .FunSel (FunSel), .I (I), .E (E), .Busy (Busy)
    );

    always #5 Clock = ~Clock;

    // Register bank model: preload port has priority over DUT writes.
    always @(posedge Clock) begin
        if (pre_en) begin
            m_reg[pre_idx] <= pre_val;
        end else begin
            for (int r = 0; r < 4; r++) begin
                if (E[r]) begin
                    case (FunSel)
                        3'b000: m_reg[r] <= m_reg[r] - 16'd1;
                        3'b001: m_reg[r] <= m_reg[r] + 16'd1;
                        3'b010: m_reg[r] <= I;
                        3'b011: m_reg[r] <= 16'h0000;
                        3'b100: m_reg[r] <= {8'h00, I[7:0]};
                        3'b101: m_reg[r] <= {m_reg[r][15:8], I[7:0]};
                        3'b110: m_reg[r] <= {I[7:0], m_reg[r][7:0]};
                        default: m_reg[r] <= {{8{I[7]}}, I[7:0]};
                    endcase
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic preload(input logic [1:0] idx, input logic [15:0] val);
        pre_en = 1'b1; pre_idx = idx; pre_val = val;
        tick();
        pre_en = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; ReqA = 1'b1; ReqB = 1'b1;
        tick();
        tick();
        n_cmp++; if ({GntA, GntB, DoneA, DoneB, Err, Busy} !== 6'b0) begin n_fail++; $display("FAIL reset_ctrl got %b exp 000000", {GntA, GntB, DoneA, DoneB, Err, Busy}); end
        n_cmp++; if ({E, FunSel, I} !== 23'h0) begin n_fail++; $display("FAIL reset_bus got E=%b FS=%b I=%h exp zeros", E, FunSel, I); end
        Reset = 1'b0; ReqA = 1'b0; ReqB = 1'b0;
        tick();
        n_cmp++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle Busy got %b exp 0", Busy); end
    endtask

    task automatic test_inc();
        preload(2'd2, 16'h00FF);
        ReqA = 1'b1; OpA = 3'd1; SelA = 2'd2; DataA = 16'h0000;
        tick();
        n_cmp++; if (E !== 4'b0100) begin n_fail++; $display("FAIL inc_E got %b exp 0100", E); end
        n_cmp++; if (FunSel !== 3'b001) begin n_fail++; $display("FAIL inc_FS got %b exp 001", FunSel); end
        n_cmp++; if ({GntA, GntB, Busy, DoneA} !== 4'b1010) begin n_fail++; $display("FAIL inc_exec_ctrl got %b exp 1010", {GntA, GntB, Busy, DoneA}); end
        tick();
        n_cmp++; if ({DoneA, DoneB, Err, GntA} !== 4'b1001) begin n_fail++; $display("FAIL inc_done got %b exp 1001", {DoneA, DoneB, Err, GntA}); end
        n_cmp++; if ({E, FunSel, I} !== 23'h0) begin n_fail++; $display("FAIL inc_done_bus got E=%b FS=%b I=%h exp zeros", E, FunSel, I); end
        n_cmp++; if (m_reg[2] !== 16'h0100) begin n_fail++; $display("FAIL inc_reg got %h exp 0100", m_reg[2]); end
        ReqA = 1'b0;
        tick();
        n_cmp++; if ({DoneA, GntA, Busy} !== 3'b000) begin n_fail++; $display("FAIL inc_idle got %b exp 000", {DoneA, GntA, Busy}); end
    endtask

    task automatic test_ldw();
        preload(2'd1, 16'h0000);
        ReqB = 1'b1; OpB = 3'd5; SelB = 2'd1; DataB = 16'hBEEF;
        tick();
        n_cmp++; if ({E, FunSel, I, GntB} !== {4'b0010, 3'b101, 16'h00EF, 1'b1}) begin n_fail++; $display("FAIL ldw_lo got E=%b FS=%b I=%h G=%b exp 0010/101/00ef/1", E, FunSel, I, GntB); end
        tick();
        n_cmp++; if ({E, FunSel, I, DoneB} !== {4'b0010, 3'b110, 16'h00BE, 1'b0}) begin n_fail++; $display("FAIL ldw_hi got E=%b FS=%b I=%h D=%b exp 0010/110/00be/0", E, FunSel, I, DoneB); end
        tick();
        n_cmp++; if ({DoneB, DoneA, Err, E} !== 7'b1000000) begin n_fail++; $display("FAIL ldw_done got %b exp 1000000", {DoneB, DoneA, Err, E}); end
        n_cmp++; if (m_reg[1] !== 16'hBEEF) begin n_fail++; $display("FAIL ldw_reg got %h exp beef", m_reg[1]); end
        ReqB = 1'b0;
        tick();
        n_cmp++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL ldw_idle Busy got %b exp 0", Busy); end
    endtask

    task automatic test_arbitration();
        do_reset();
        preload(2'd0, 16'h1111);
        preload(2'd3, 16'h3333);
        ReqA = 1'b1; OpA = 3'd2; SelA = 2'd0; DataA = 16'h0000;
        ReqB = 1'b1; OpB = 3'd2; SelB = 2'd3; DataB = 16'h0000;
        tick();
        n_cmp++; if ({GntA, GntB, E} !== 6'b10_0001) begin n_fail++; $display("FAIL arb_first got %b exp 100001", {GntA, GntB, E}); end
        n_cmp++; if (FunSel !== 3'b011) begin n_fail++; $display("FAIL arb_clr_FS got %b exp 011", FunSel); end
        tick();
        n_cmp++; if ({DoneA, DoneB} !== 2'b10) begin n_fail++; $display("FAIL arb_doneA got %b exp 10", {DoneA, DoneB}); end
        n_cmp++; if (m_reg[0] !== 16'h0000) begin n_fail++; $display("FAIL arb_r0 got %h exp 0000", m_reg[0]); end
        tick();
        n_cmp++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL arb_gap Busy got %b exp 0", Busy); end
        tick();
        n_cmp++; if ({GntA, GntB, E} !== 6'b01_1000) begin n_fail++; $display("FAIL arb_second got %b exp 011000", {GntA, GntB, E}); end
        tick();
        n_cmp++; if ({DoneA, DoneB} !== 2'b01) begin n_fail++; $display("FAIL arb_doneB got %b exp 01", {DoneA, DoneB}); end
        n_cmp++; if (m_reg[3] !== 16'h0000) begin n_fail++; $display("FAIL arb_r3 got %h exp 0000", m_reg[3]); end
        ReqB = 1'b0;
        tick();
        tick();
        n_cmp++; if ({GntA, GntB, E} !== 6'b10_0001) begin n_fail++; $display("FAIL arb_third got %b exp 100001", {GntA, GntB, E}); end
        tick();
        ReqA = 1'b0;
        tick();
    endtask

    task automatic test_lds_ldz();
        preload(2'd0, 16'h1234);
        ReqA = 1'b1; OpA = 3'd4; SelA = 2'd0; DataA = 16'h0080;
        tick();
        n_cmp++; if ({FunSel, I} !== {3'b111, 16'h0080}) begin n_fail++; $display("FAIL lds_bus got FS=%b I=%h exp 111/0080", FunSel, I); end
        tick();
        n_cmp++; if (m_reg[0] !== 16'hFF80) begin n_fail++; $display("FAIL lds_reg got %h exp ff80", m_reg[0]); end
        ReqA = 1'b0;
        tick();
        ReqA = 1'b1; OpA = 3'd3;
        tick();
        n_cmp++; if ({FunSel, I} !== {3'b100, 16'h0080}) begin n_fail++; $display("FAIL ldz_bus got FS=%b I=%h exp 100/0080", FunSel, I); end
        tick();
        n_cmp++; if (m_reg[0] !== 16'h0080) begin n_fail++; $display("FAIL ldz_reg got %h exp 0080", m_reg[0]); end
        ReqA = 1'b0;
        tick();
    endtask

    task automatic test_illegal();
        preload(2'd2, 16'h5A5A);
        ReqB = 1'b1; OpB = 3'd6; SelB = 2'd2; DataB = 16'hFFFF;
        tick();
        n_cmp++; if ({E, FunSel, GntB} !== 8'b0000_000_1) begin n_fail++; $display("FAIL ill_exec got E=%b FS=%b G=%b exp 0000/000/1", E, FunSel, GntB); end
        tick();
        n_cmp++; if ({DoneB, Err, E} !== 6'b11_0000) begin n_fail++; $display("FAIL ill_done got %b exp 110000", {DoneB, Err, E}); end
        ReqB = 1'b0;
        tick();
        n_cmp++; if ({Err, DoneB} !== 2'b00) begin n_fail++; $display("FAIL ill_after got %b exp 00", {Err, DoneB}); end
        n_cmp++; if (m_reg[2] !== 16'h5A5A) begin n_fail++; $display("FAIL ill_reg got %h exp 5a5a", m_reg[2]); end
    endtask

    task automatic test_reset_mid_ldw();
        preload(2'd3, 16'hFFFF);
        ReqA = 1'b1; OpA = 3'd5; SelA = 2'd3; DataA = 16'h1234;
        tick();
        n_cmp++; if ({E, FunSel} !== 7'b1000_101) begin n_fail++; $display("FAIL rst_ldw_lo got E=%b FS=%b exp 1000/101", E, FunSel); end
        // Reset lands on the edge that would begin the high-byte write.
        Reset = 1'b1;
        tick();
        n_cmp++; if ({E, FunSel, I} !== 23'h0) begin n_fail++; $display("FAIL rst_ldw_bus got E=%b FS=%b I=%h exp zeros", E, FunSel, I); end
        n_cmp++; if ({GntA, DoneA, Err, Busy} !== 4'b0000) begin n_fail++; $display("FAIL rst_ldw_ctrl got %b exp 0000", {GntA, DoneA, Err, Busy}); end
        n_cmp++; if (m_reg[3] !== 16'hFF34) begin n_fail++; $display("FAIL rst_ldw_reg got %h exp ff34", m_reg[3]); end
        Reset = 1'b0; ReqA = 1'b0;
        tick();
        n_cmp++; if ({DoneA, Busy, E} !== 6'b0) begin n_fail++; $display("FAIL rst_ldw_after got %b exp 000000", {DoneA, Busy, E}); end
        tick();
        n_cmp++; if (DoneA !== 1'b0) begin n_fail++; $display("FAIL rst_ldw_nodone got %b exp 0", DoneA); end
        n_cmp++; if (m_reg[3] !== 16'hFF34) begin n_fail++; $display("FAIL rst_ldw_hold got %h exp ff34", m_reg[3]); end
    endtask

    initial begin
        Reset = 1'b1;
        ReqA = 1'b0; ReqB = 1'b0;
        OpA = 3'd0; OpB = 3'd0; SelA = 2'd0; SelB = 2'd0;
        DataA = 16'h0000; DataB = 16'h0000;
        test_reset();
        test_inc();
        test_ldw();
        test_arbitration();
        test_lds_ldz();
        test_illegal();
        test_reset_mid_ldw();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
